// File: rtl/ula_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the execute-stage
// ULA for one add (multiply) or subtract (divide) per iteration and owns HI/LO.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; latches op and operands when start is seen
// PREP   | take operand magnitudes, record result signs, seed accumulators
// ITER   | one shift-add or restoring-divide step per cycle via the ULA
// FIX    | apply signs, handle divide-by-zero, load HI/LO
// DONE   | done pulse, HI/LO valid
module ula_muldiv_ctrl #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic [XLEN-1:0] ula_result,
  output logic [XLEN-1:0] ula_in1,
  output logic [XLEN-1:0] ula_in2,
  output logic [3:0]      ula_op,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam logic [3:0] ULA_ADD = 4'b0010;
  localparam logic [3:0] ULA_SUB = 4'b0110;
  localparam int CW = $clog2(ITER);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] rs_q, rs_d, rt_q, rt_d;
  // multiply: addend |rs|; divide: divisor |rt|
  logic [XLEN-1:0] opnd_q, opnd_d;
  // multiply: {acc_hi, acc_lo}; divide: {R, Q}
  logic [XLEN-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q_q, sign_q_d, sign_r_q, sign_r_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            dbz_q, dbz_d;

  logic            is_div, is_signed;
  logic [XLEN-1:0] mag_rs, mag_rt, r_sh;
  logic            carry, msb;
  logic [2*XLEN-1:0] prod;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];

  // Next-state, datapath updates and ULA drive; ULA inputs are zero outside ITER.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    ula_op   = 4'b0000;
    ula_in1  = '0;
    ula_in2  = '0;
    mag_rs   = (is_signed && rs_q[XLEN-1]) ? -rs_q : rs_q;
    mag_rt   = (is_signed && rt_q[XLEN-1]) ? -rt_q : rt_q;
    r_sh     = {acc_hi_q[XLEN-2:0], acc_lo_q[XLEN-1]};
    msb      = acc_hi_q[XLEN-1];
    carry    = 1'b0;
    prod     = {acc_hi_q, acc_lo_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          rs_d    = rs_val;
          rt_d    = rt_val;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        sign_q_d = is_signed & (rs_q[XLEN-1] ^ rt_q[XLEN-1]);
        sign_r_d = is_signed & rs_q[XLEN-1];
        opnd_d   = is_div ? mag_rt : mag_rs;
        acc_hi_d = '0;
        acc_lo_d = is_div ? mag_rs : mag_rt;
        cnt_d    = CW'(ITER - 1);
        state_d  = S_ITER;
      end
      S_ITER: begin
        if (!is_div) begin
          ula_op   = ULA_ADD;
          ula_in1  = acc_hi_q;
          ula_in2  = acc_lo_q[0] ? opnd_q : '0;
          carry    = (ula_result < acc_hi_q);
          acc_hi_d = {carry, ula_result[XLEN-1:1]};
          acc_lo_d = {ula_result[0], acc_lo_q[XLEN-1:1]};
        end else begin
          ula_op  = ULA_SUB;
          ula_in1 = r_sh;
          ula_in2 = opnd_q;
          // a set shifted-out msb means the true remainder exceeds XLEN bits,
          // so the subtraction always fits and the wrapped result is exact
          if (msb || (r_sh >= opnd_q)) begin
            acc_hi_d = ula_result;
            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
          end else begin
            acc_hi_d = r_sh;
            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
          end
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        dbz_d = 1'b0;
        if (is_div) begin
          if (rt_q == '0) begin
            hi_d  = rs_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            lo_d = sign_q_q ? -acc_lo_q : acc_lo_q;
            hi_d = sign_r_q ? -acc_hi_q : acc_hi_q;
          end
        end else begin
          if (sign_q_q) prod = -prod;
          hi_d = prod[2*XLEN-1:XLEN];
          lo_d = prod[XLEN-1:0];
        end
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register update with synchronous reset that aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = done & dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: doc/ula_muldiv_ctrl.md
Name: ula_muldiv_ctrl

Overview:
Multi-cycle sequencer that executes MULT/MULTU/DIV/DIVU by time-sharing the single-cycle ULA. It uses the ULA's ADD (4'b0010) and SUB (4'b0110) codes for one iteration per cycle, and writes the 64-bit result into the HI/LO registers it owns. It sits beside the ULA in the execute stage. The main control stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
XLEN, 32, operand/result width; ULA opcode constants are fixed to the ULA encoding.
ITER, 32, iterations per operation (equals XLEN).

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
rs_val  input  32  multiplicand / dividend
rt_val  input  32  multiplier / divisor
ula_result  input  32  result from the shared ULA
ula_in1  output  32  ULA operand 1
ula_in2  output  32  ULA operand 2
ula_op  output  4  ULA opcode
busy  output  1  high from cycle after start through the done cycle
done  output  1  one-cycle pulse; hi/lo valid
div_by_zero  output  1  valid with done; high iff DIV/DIVU with rt_val==0
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Clock and reset: one clock, reset is synchronous and active-high. Reset forces IDLE.
- Reset values: busy=0, done=0, div_by_zero=0, hi=0, lo=0, ula_in1=0, ula_in2=0, ula_op=4'b0000. Reset mid-operation aborts the operation: no done pulse, hi/lo cleared.
- States: IDLE -> PREP -> ITER (32 cycles) -> FIX -> DONE -> IDLE.
- Latency: if start is sampled high in cycle 0, then PREP is cycle 1, ITER is cycles 2..33, FIX is cycle 34, and DONE is cycle 35 (done=1, busy=1). busy=0 again in cycle 36, when a new start may be sampled.
- Start handling: start, op and operands are latched at cycle 0. start while busy is ignored. Input changes after cycle 0 have no effect.
- PREP:
  - Signed ops compute operand magnitudes internally.
  - Record sign_q = sign(rs) XOR sign(rt) and sign_r = sign(rs).
  - Unsigned ops use operands as-is.
- ITER, multiply (shift-add), state acc_hi, acc_lo (init acc_hi=0, acc_lo=|rt|):
  - Drive ula_op=ADD, ula_in1=acc_hi, ula_in2 = acc_lo[0] ? |rs| : 0.
  - carry = (ula_result < acc_hi) unsigned.
  - Update {acc_hi, acc_lo} <= {carry, ula_result, acc_lo} >> 1.
- ITER, divide (restoring), state R (init 0), Q (init |rs|):
  - Shift {msb, R_sh, Q_sh} = {R, Q} << 1.
  - Drive ula_op=SUB, ula_in1=R_sh, ula_in2=|rt|.
  - If msb==1 or R_sh >= |rt| (unsigned): R <= ula_result and Q_sh[0] <= 1. Otherwise R <= R_sh and Q_sh[0] <= 0.
- FIX:
  - MULT with sign_q: the 64-bit product is two's-complement negated.
  - DIV: the quotient is negated if sign_q; the remainder is negated if sign_r.
  - Load hi/lo: mult hi=product[63:32], lo=product[31:0]; div lo=quotient, hi=remainder.
- Divide by zero (rt_val==0, DIV or DIVU):
  - Latency is unchanged; div_by_zero=1 with done.
  - hi=rs_val (raw), lo=32'hFFFFFFFF.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No flag is raised.
- Outside ITER (IDLE, PREP, FIX, DONE): ula_op=4'b0000, ula_in1=0, ula_in2=0.
- ULA zero_flag is not used.
- hi/lo hold their value from DONE until the next DONE or reset. done and div_by_zero are high only in the DONE cycle.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF, start at cycle 0 -> done at cycle 35, hi=0xFFFFFFFE, lo=0x00000001; busy high in cycles 1..35 only.
- MULT rs=-3 (0xFFFFFFFD), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; ula_op=0010 in cycles 2..33 and 0000 elsewhere.
- DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=100, rt=7 -> lo=14, hi=2. div_by_zero=0 in both cases.
- DIVU rs=0x64, rt=0 -> done at cycle 35, div_by_zero=1, hi=0x64, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start pulse again at cycle 5 with different operands -> ignored; the first result is unchanged. Back-to-back start at cycle 36 -> accepted, done at cycle 71.
- Reset asserted at cycle 10 of a MULT -> cycle 11: busy=0, hi=lo=0, ula outputs 0; no done pulse follows.
